// File: rtl/digit_serial_add_sub_pkg.sv
// Shared defaults, mode encoding and state encoding for the digit-serial adder/subtractor.
package digit_serial_pkg;

  localparam int DIGIT_W_DEF     = 1;
  localparam int WORD_DIGITS_DEF = 8;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/digit_serial_add_sub_if.sv
// Beat-level bus between a digit source and the serial adder/subtractor.
interface digit_serial_add_sub_if #(
  parameter int DIGIT_W = digit_serial_pkg::DIGIT_W_DEF
);
  logic               in_valid;
  logic               first;
  logic               mode;
  logic [DIGIT_W-1:0] a;
  logic [DIGIT_W-1:0] b;
  logic               out_valid;
  logic [DIGIT_W-1:0] sum;
  logic               out_last;
  logic               carry_out;
  logic               overflow;
  logic               err;

  modport master (
    output in_valid, first, mode, a, b,
    input  out_valid, sum, out_last, carry_out, overflow, err
  );

  modport slave (
    input  in_valid, first, mode, a, b,
    output out_valid, sum, out_last, carry_out, overflow, err
  );
endinterface

// File: rtl/digit_serial_add_sub_fa.sv
// Combinational ripple of W full adders built from gates only; also exposes the
// carry into the top bit so the caller can form signed overflow.
module digit_full_adder #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         cmsb_in
);
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic p;
    assign p      = a[i] ^ b[i];
    assign s[i]   = p ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & p);
  end

  assign cout    = c[W];
  assign cmsb_in = c[W-1];
endmodule

// File: rtl/digit_serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor, LSB digit first, one digit per cycle.
//   state   | meaning
//   ST_IDLE | no word open; only a first beat is accepted
//   ST_BUSY | word open; next beat continues it at digit index cnt
module digit_serial_add_sub
  import digit_serial_pkg::*;
#(
  parameter int DIGIT_W     = DIGIT_W_DEF,
  parameter int WORD_DIGITS = WORD_DIGITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  digit_serial_add_sub_if.slave  bus
);
  localparam int               CNT_W    = $clog2(WORD_DIGITS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_DIGITS - 1);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, idx;
  logic               carry_q, carry_nxt;
  mode_e              mode_q, mode_nxt, mode_eff;

  logic               cin, take, is_last, stray;
  logic [DIGIT_W-1:0] b_eff, s;
  logic               cout, cmsb_in;

  logic               out_valid_q, out_last_q, carry_out_q, overflow_q, err_q;
  logic [DIGIT_W-1:0] sum_q;

  // A first beat restarts the word regardless of state, so it overrides all held context.
  always_comb begin
    mode_eff = bus.first ? mode_e'(bus.mode) : mode_q;
    cin      = bus.first ? bus.mode : carry_q;
    idx      = bus.first ? '0 : cnt;
    take     = bus.in_valid && (bus.first || (state == ST_BUSY));
    is_last  = take && (idx == LAST_IDX);
    stray    = bus.in_valid && !bus.first && (state == ST_IDLE);
    b_eff    = bus.b ^ {DIGIT_W{mode_eff == MODE_SUB}};
  end

  digit_full_adder #(.W(DIGIT_W)) u_fa (
    .a       (bus.a),
    .b       (b_eff),
    .cin     (cin),
    .s       (s),
    .cout    (cout),
    .cmsb_in (cmsb_in)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    carry_nxt = carry_q;
    mode_nxt  = mode_q;
    if (take) begin
      carry_nxt = cout;
      mode_nxt  = mode_eff;
      if (is_last) begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end else begin
        state_nxt = ST_BUSY;
        cnt_nxt   = idx + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      carry_q <= 1'b0;
      mode_q  <= MODE_ADD;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      carry_q <= carry_nxt;
      mode_q  <= mode_nxt;
    end
  end

  // Result flags exist only alongside the final digit; otherwise forced low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= take;
      if (take) sum_q <= s;
      out_last_q  <= is_last;
      carry_out_q <= is_last & cout;
      overflow_q  <= is_last & (cmsb_in ^ cout);
      err_q       <= stray;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.out_last  = out_last_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Scoreboard bench: two instances (1-bit x 8 digits, 4-bit x 2 digits), both 8-bit words,
// checked against a signed/unsigned arithmetic reference model.
module tb_digit_serial_add_sub;

  typedef struct packed {
    logic [3:0] sum;
    logic       last;
    logic       carry;
    logic       ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;
  logic rst_seen1 = 1'b1;
  logic rst_seen2 = 1'b1;

  exp_t q1[$];
  exp_t q2[$];
  int checks = 0;
  int errors = 0;
  int err_seen1 = 0, err_exp1 = 0;
  int err_seen2 = 0, err_exp2 = 0;
  logic       prev_sum1 = 1'b0;
  logic [3:0] prev_sum2 = 4'h0;

  digit_serial_add_sub_if #(.DIGIT_W(1)) d1 ();
  digit_serial_add_sub_if #(.DIGIT_W(4)) d2 ();

  digit_serial_add_sub #(.DIGIT_W(1), .WORD_DIGITS(8)) u_dut1 (
    .clk (clk), .rst (rst1), .bus (d1)
  );
  digit_serial_add_sub #(.DIGIT_W(4), .WORD_DIGITS(2)) u_dut2 (
    .clk (clk), .rst (rst2), .bus (d2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rst_seen1 <= rst1;
    rst_seen2 <= rst2;
  end

  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic m,
                                output logic [7:0] r, output logic c, output logic ov);
    int sa, sb, res;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    res = m ? (sa - sb) : (sa + sb);
    ov  = (res > 127) || (res < -128);
    r   = m ? 8'(a - b) : 8'(a + b);
    c   = m ? (a >= b) : ((int'(a) + int'(b)) > 255);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- instance 1 (DIGIT_W=1, WORD_DIGITS=8) ----------------
  task automatic beat1(input logic v, input logic f, input logic m, input logic a, input logic b);
    d1.in_valid = v; d1.first = f; d1.mode = m; d1.a = a; d1.b = b;
    @(posedge clk); #1;
  endtask

  task automatic idle1(input int n);
    repeat (n) beat1(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic word1(input logic [7:0] a, input logic [7:0] b, input logic m,
                       input int ndig, input int gap_at, input int gap_len);
    logic [7:0] r;
    logic c, ov;
    exp_t e;
    model(a, b, m, r, c, ov);
    for (int i = 0; i < ndig; i++) begin
      beat1(1'b1, i == 0, (i == 0) ? m : 1'($urandom), a[i], b[i]);
      e.sum   = {3'b000, r[i]};
      e.last  = (i == 7);
      e.carry = (i == 7) & c;
      e.ov    = (i == 7) & ov;
      q1.push_back(e);
      if (i == gap_at) idle1(gap_len);
    end
  endtask

  // ---------------- instance 2 (DIGIT_W=4, WORD_DIGITS=2) ----------------
  task automatic beat2(input logic v, input logic f, input logic m,
                       input logic [3:0] a, input logic [3:0] b);
    d2.in_valid = v; d2.first = f; d2.mode = m; d2.a = a; d2.b = b;
    @(posedge clk); #1;
  endtask

  task automatic idle2(input int n);
    repeat (n) beat2(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic word2(input logic [7:0] a, input logic [7:0] b, input logic m,
                       input int ndig, input int gap_at, input int gap_len);
    logic [7:0] r;
    logic c, ov;
    exp_t e;
    model(a, b, m, r, c, ov);
    for (int i = 0; i < ndig; i++) begin
      beat2(1'b1, i == 0, (i == 0) ? m : 1'($urandom), a[i*4 +: 4], b[i*4 +: 4]);
      e.sum   = r[i*4 +: 4];
      e.last  = (i == 1);
      e.carry = (i == 1) & c;
      e.ov    = (i == 1) & ov;
      q2.push_back(e);
      if (i == gap_at) idle2(gap_len);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen1) begin
      if (!rst1) chk("rst_outs1",
        32'({d1.out_valid, d1.sum, d1.out_last, d1.carry_out, d1.overflow, d1.err}), 32'(0));
      prev_sum1 = 1'b0;
    end else if (d1.out_valid) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out1: got out_valid=1 expected no output at %0t", $time);
      end else begin
        e = q1.pop_front();
        chk("digit1", 32'({d1.sum, d1.out_last, d1.carry_out, d1.overflow}),
                      32'({e.sum[0], e.last, e.carry, e.ov}));
      end
      prev_sum1 = d1.sum;
      if (d1.err) err_seen1++;
    end else begin
      chk("idle1", 32'({d1.sum, d1.out_last, d1.carry_out, d1.overflow}),
                   32'({prev_sum1, 3'b000}));
      if (d1.err) err_seen1++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_seen2) begin
      if (!rst2) chk("rst_outs2",
        32'({d2.out_valid, d2.sum, d2.out_last, d2.carry_out, d2.overflow, d2.err}), 32'(0));
      prev_sum2 = 4'h0;
    end else if (d2.out_valid) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out2: got out_valid=1 expected no output at %0t", $time);
      end else begin
        e = q2.pop_front();
        chk("digit2", 32'({d2.sum, d2.out_last, d2.carry_out, d2.overflow}),
                      32'({e.sum, e.last, e.carry, e.ov}));
      end
      prev_sum2 = d2.sum;
      if (d2.err) err_seen2++;
    end else begin
      chk("idle2", 32'({d2.sum, d2.out_last, d2.carry_out, d2.overflow}),
                   32'({prev_sum2, 3'b000}));
      if (d2.err) err_seen2++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    d1.in_valid = 1'b0; d1.first = 1'b0; d1.mode = 1'b0; d1.a = '0; d1.b = '0;
    d2.in_valid = 1'b0; d2.first = 1'b0; d2.mode = 1'b0; d2.a = '0; d2.b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst1 = 1'b0;
    rst2 = 1'b0;
    idle1(1);

    fork
      begin
        word1(8'h5A, 8'h3C, 1'b0, 8, -1, 0);
        word1(8'h10, 8'h20, 1'b1, 8, -1, 0);
        word1(8'h5A, 8'h3C, 1'b0, 8, 3, 3);
        word1(8'($urandom), 8'($urandom), 1'($urandom), 5, -1, 0);
        word1(8'h01, 8'h01, 1'b0, 8, -1, 0);
        // reset mid-word with a beat present, then a stray non-first beat
        word1(8'($urandom), 8'($urandom), 1'($urandom), 4, -1, 0);
        rst1 = 1'b1;
        beat1(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        rst1 = 1'b0;
        beat1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        err_exp1++;
        idle1(2);
        for (int n = 0; n < 30; n++) begin
          int kind;
          kind = int'($urandom_range(0, 7));
          if (kind == 6) begin
            beat1(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            err_exp1++;
          end else if (kind == 7) begin
            word1(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(1, 7)), -1, 0);
            word1(8'($urandom), 8'($urandom), 1'($urandom), 8, -1, 0);
          end else begin
            word1(8'($urandom), 8'($urandom), 1'($urandom), 8,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
          end
        end
        idle1(3);
      end
      begin
        word2(8'hFF, 8'h01, 1'b0, 2, -1, 0);
        word2(8'h80, 8'h01, 1'b1, 2, -1, 0);
        for (int n = 0; n < 30; n++) begin
          int kind;
          kind = int'($urandom_range(0, 5));
          if (kind == 4) begin
            beat2(1'b1, 1'b0, 1'($urandom), 4'($urandom), 4'($urandom));
            err_exp2++;
          end else if (kind == 5) begin
            word2(8'($urandom), 8'($urandom), 1'($urandom), 1, -1, 0);
            word2(8'($urandom), 8'($urandom), 1'($urandom), 2, -1, 0);
          end else begin
            word2(8'($urandom), 8'($urandom), 1'($urandom), 2,
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
          end
        end
        idle2(3);
      end
    join

    t = 0;
    while ((q1.size() != 0 || q2.size() != 0) && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (q1.size() != 0 || q2.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending digits expected 0/0", q1.size(), q2.size());
    end
    repeat (2) @(posedge clk);
    #1;
    chk("err_count1", 32'(err_seen1), 32'(err_exp1));
    chk("err_count2", 32'(err_seen2), 32'(err_exp2));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
